// File: rtl/seq_detect_moore.sv
// Moore serial pattern detector with a runtime-programmable pattern, overlap mode,
// an input valid qualifier and a saturating match counter.
module seq_detect_moore #(
  parameter int               PAT_W   = 4,
  parameter int               CNT_W   = 8,
  parameter logic [PAT_W-1:0] PAT_RST = PAT_W'(4'b1011),
  localparam int              PW      = $clog2(PAT_W + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_we,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic             cfg_overlap,
  input  logic             cnt_clr,
  input  logic             in_valid,
  input  logic             data_in,
  output logic             detect,
  output logic [PW-1:0]    progress,
  output logic [CNT_W-1:0] match_count
);

  localparam logic [PW-1:0] P_FULL = PW'(PAT_W);

  logic [PW-1:0]    p_q, p_next;
  logic [PAT_W-2:0] hist_q, hist_next;
  logic [PAT_W-1:0] pat_q;
  logic             overlap_q;
  logic [CNT_W-1:0] cnt_q, cnt_next;

  logic [PAT_W-1:0] window;
  int               limit;
  int               best;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves it unassigned (no latches).
    p_next    = p_q;
    hist_next = hist_q;
    cnt_next  = cnt_q;
    window    = {hist_q, data_in};
    best      = 0;
    limit     = 0;

    if (cfg_we) begin
      p_next    = '0;
      hist_next = '0;
    end else if (in_valid) begin
      // After a full match in non-overlapping mode only the new bit may start a match.
      if (p_q == P_FULL && !overlap_q) limit = 1;
      else if (int'(p_q) + 1 > PAT_W) limit = PAT_W;
      else                             limit = int'(p_q) + 1;

      // Longest suffix of the accepted stream that is also a pattern prefix.
      for (int k = 1; k <= PAT_W; k++) begin
        if (k <= limit &&
            (window & ({PAT_W{1'b1}} >> (PAT_W - k))) == (pat_q >> (PAT_W - k)))
          best = k;
      end
      p_next    = PW'(best);
      hist_next = window[PAT_W-2:0];
      if (best == PAT_W && cnt_q != '1) cnt_next = cnt_q + 1'b1;
    end

    if (cnt_clr) cnt_next = '0;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_q       <= '0;
      hist_q    <= '0;
      pat_q     <= PAT_RST;
      overlap_q <= 1'b1;
      cnt_q     <= '0;
    end else begin
      p_q    <= p_next;
      hist_q <= hist_next;
      cnt_q  <= cnt_next;
      if (cfg_we) begin
        pat_q     <= cfg_pattern;
        overlap_q <= cfg_overlap;
      end
    end
  end

  assign detect      = (p_q == P_FULL);
  assign progress    = p_q;
  assign match_count = cnt_q;

endmodule

// File: tb/tb_seq_detect_moore.sv
// Directed scoreboard bench: two instances (8-bit and 2-bit counters) share all stimulus.
module tb_seq_detect_moore;

  logic       clk = 1'b0;
  logic       rst;
  logic       cfg_we;
  logic [3:0] cfg_pattern;
  logic       cfg_overlap;
  logic       cnt_clr;
  logic       in_valid;
  logic       data_in;

  logic       detect, detect2;
  logic [2:0] progress, progress2;
  logic [7:0] match_count;
  logic [1:0] match_count2;

  seq_detect_moore #(.PAT_W(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
    .cfg_overlap(cfg_overlap), .cnt_clr(cnt_clr), .in_valid(in_valid),
    .data_in(data_in), .detect(detect), .progress(progress),
    .match_count(match_count)
  );

  seq_detect_moore #(.PAT_W(4), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
    .cfg_overlap(cfg_overlap), .cnt_clr(cnt_clr), .in_valid(in_valid),
    .data_in(data_in), .detect(detect2), .progress(progress2),
    .match_count(match_count2)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] p;
    logic       det;
    logic [7:0] cnt;
    logic [1:0] cnt2;
    string      tag;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  function automatic exp_t mk(input logic [2:0] p, input int cnt, input string tag);
    exp_t e;
    e.p    = p;
    e.det  = (p == 3'd4);
    e.cnt  = 8'(cnt);
    e.cnt2 = (cnt > 3) ? 2'd3 : 2'(cnt);
    e.tag  = tag;
    return e;
  endfunction

  task automatic compare_head();
    exp_t e;
    if (exp_q.size() == 0) begin
      n_vec++; n_err++;
      $error("FAIL scoreboard_empty observed=0 expected=1");
      return;
    end
    e = exp_q.pop_front();
    n_vec++;
    assert (progress === e.p) else begin
      n_err++; $error("FAIL %s progress observed=%0d expected=%0d", e.tag, progress, e.p);
    end
    n_vec++;
    assert (detect === e.det) else begin
      n_err++; $error("FAIL %s detect observed=%0b expected=%0b", e.tag, detect, e.det);
    end
    n_vec++;
    assert (match_count === e.cnt) else begin
      n_err++; $error("FAIL %s match_count observed=%0d expected=%0d", e.tag, match_count, e.cnt);
    end
    n_vec++;
    assert (match_count2 === e.cnt2) else begin
      n_err++; $error("FAIL %s match_count2 observed=%0d expected=%0d", e.tag, match_count2, e.cnt2);
    end
    n_vec++;
    assert (progress2 === e.p) else begin
      n_err++; $error("FAIL %s progress2 observed=%0d expected=%0d", e.tag, progress2, e.p);
    end
  endtask

  // Drive one cycle of stimulus, push its expected outcome, sample #1 after the edge.
  task automatic step(input logic v, input logic b, input logic we, input logic clr,
                      input logic [2:0] ep, input int ecnt, input string tag);
    in_valid = v;
    data_in  = b;
    cfg_we   = we;
    cnt_clr  = clr;
    exp_q.push_back(mk(ep, ecnt, tag));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    cfg_we   = 1'b0;
    cnt_clr  = 1'b0;
    compare_head();
  endtask

  task automatic cfg(input logic [3:0] pat, input logic ovl, input int ecnt, input string tag);
    cfg_pattern = pat;
    cfg_overlap = ovl;
    step(1'b0, 1'b0, 1'b1, 1'b0, 3'd0, ecnt, tag);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; cfg_we = 1'b0; cfg_pattern = 4'b0000; cfg_overlap = 1'b0;
    cnt_clr = 1'b0; in_valid = 1'b0; data_in = 1'b0;
    #12;
    exp_q.push_back(mk(3'd0, 0, "reset"));
    compare_head();
    rst = 1'b0;
    @(posedge clk); #1;

    // Reset pattern 1011, overlapping.
    step(1, 1, 0, 0, 3'd1, 0, "ov_b1");
    step(1, 0, 0, 0, 3'd2, 0, "ov_b2");
    step(1, 1, 0, 0, 3'd3, 0, "ov_b3");
    step(1, 1, 0, 0, 3'd4, 1, "ov_b4");
    step(1, 0, 0, 0, 3'd2, 1, "ov_b5");
    step(1, 1, 0, 0, 3'd3, 1, "ov_b6");
    step(1, 1, 0, 0, 3'd4, 2, "ov_b7");

    // Non-overlapping: after a match only the new bit may restart.
    cfg(4'b1011, 1'b0, 2, "cfg_novl");
    step(0, 0, 0, 1, 3'd0, 0, "clr_idle");
    step(1, 1, 0, 0, 3'd1, 0, "no_b1");
    step(1, 0, 0, 0, 3'd2, 0, "no_b2");
    step(1, 1, 0, 0, 3'd3, 0, "no_b3");
    step(1, 1, 0, 0, 3'd4, 1, "no_b4");
    step(1, 0, 0, 0, 3'd0, 1, "no_b5");
    step(1, 1, 0, 0, 3'd1, 1, "no_b6");
    step(1, 1, 0, 0, 3'd1, 1, "no_b7");

    // Longest-suffix fallback on 1100.
    cfg(4'b1100, 1'b1, 1, "cfg_1100");
    step(1, 1, 0, 0, 3'd1, 1, "fb_b1");
    step(1, 1, 0, 0, 3'd2, 1, "fb_b2");
    step(1, 1, 0, 0, 3'd2, 1, "fb_b3");
    step(1, 0, 0, 0, 3'd3, 1, "fb_b4");
    step(1, 0, 0, 0, 3'd4, 2, "fb_b5");

    // Gapped input: state holds while in_valid is low; detect persists after the match.
    cfg(4'b1011, 1'b1, 2, "cfg_gap");
    step(1, 1, 0, 0, 3'd1, 2, "gap_b1");
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 3'd1, 2, "gap_idle1");
    step(1, 0, 0, 0, 3'd2, 2, "gap_b2");
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 3'd2, 2, "gap_idle2");
    step(1, 1, 0, 0, 3'd3, 2, "gap_b3");
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 3'd3, 2, "gap_idle3");
    step(1, 1, 0, 0, 3'd4, 3, "gap_b4");
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 3'd4, 3, "gap_hold");

    // cfg_we with a valid bit at p=3: bit dropped, p cleared, count kept.
    cfg(4'b1011, 1'b1, 3, "cfg_re");
    step(1, 1, 0, 0, 3'd1, 3, "we_b1");
    step(1, 0, 0, 0, 3'd2, 3, "we_b2");
    step(1, 1, 0, 0, 3'd3, 3, "we_b3");
    cfg_pattern = 4'b1011; cfg_overlap = 1'b1;
    step(1, 1, 1, 0, 3'd0, 3, "we_drop");
    step(1, 1, 0, 0, 3'd1, 3, "we_after");

    // Saturation on 1111; then clear wins over a coinciding match.
    step(0, 0, 0, 1, 3'd1, 0, "sat_clr");
    cfg(4'b1111, 1'b1, 0, "cfg_1111");
    step(1, 1, 0, 0, 3'd1, 0, "sat_b1");
    step(1, 1, 0, 0, 3'd2, 0, "sat_b2");
    step(1, 1, 0, 0, 3'd3, 0, "sat_b3");
    for (int i = 1; i <= 4; i++) step(1, 1, 0, 0, 3'd4, i, "sat_run");
    step(1, 1, 0, 1, 3'd4, 0, "sat_clr_hit");

    // Asynchronous reset between edges, then pattern/overlap back to defaults.
    step(1, 1, 0, 0, 3'd4, 1, "pre_rst");
    #3;
    rst = 1'b1;
    #1;
    exp_q.push_back(mk(3'd0, 0, "async_rst"));
    compare_head();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    step(1, 1, 0, 0, 3'd1, 0, "rs_b1");
    step(1, 0, 0, 0, 3'd2, 0, "rs_b2");
    step(1, 1, 0, 0, 3'd3, 0, "rs_b3");
    step(1, 1, 0, 0, 3'd4, 1, "rs_b4");
    step(1, 0, 0, 0, 3'd2, 1, "rs_b5");
    step(1, 1, 0, 0, 3'd3, 1, "rs_b6");
    step(1, 1, 0, 0, 3'd4, 2, "rs_b7");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
